// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: data width, access-size
// encodings and the FSM state type.
package lsu_pkg;

    localparam int unsigned XLEN = 64;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_WR,
        S_RESP
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational data alignment for the load/store unit.
// Ports:
//   size        access size (SZ_B/SZ_H/SZ_W/SZ_D)
//   is_unsigned zero-extend loads instead of sign-extending
//   read_data   doubleword returned by the memory
//   wdata       store data (low bytes significant below double)
//   load_c      extended load value
//   store_c     read-modify-write merged doubleword
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    input  logic [XLEN-1:0] read_data,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_c,
    output logic [XLEN-1:0] store_c
);

    // Fill bit for the upper part of a narrow load.
    logic fill_b;
    logic fill_h;
    logic fill_w;

    assign fill_b = ~is_unsigned & read_data[7];
    assign fill_h = ~is_unsigned & read_data[15];
    assign fill_w = ~is_unsigned & read_data[31];

    always_comb begin
        load_c  = read_data;
        store_c = wdata;
        case (size)
            SZ_B: begin
                load_c  = {{56{fill_b}}, read_data[7:0]};
                store_c = {read_data[63:8], wdata[7:0]};
            end
            SZ_H: begin
                load_c  = {{48{fill_h}}, read_data[15:0]};
                store_c = {read_data[63:16], wdata[15:0]};
            end
            SZ_W: begin
                load_c  = {{32{fill_w}}, read_data[31:0]};
                store_c = {read_data[63:32], wdata[31:0]};
            end
            default: begin
                load_c  = read_data;
                store_c = wdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory master: takes one load/store request at a time, runs the
// memory read / write cycles (read-modify-write for narrow stores),
// extends load data and reports out-of-range faults.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             request handshake (accepted in IDLE)
//   req_we, req_size, req_unsigned  request kind
//   req_addr, req_wdata             byte address, store data
//   resp_valid, resp_rdata, resp_fault  one-cycle response
//   Mem_Addr, Write_Data, MemWrite, MemRead, Read_Data  memory port
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_fault,
    output logic [XLEN-1:0] Mem_Addr,
    output logic [XLEN-1:0] Write_Data,
    output logic            MemWrite,
    output logic            MemRead,
    input  logic [XLEN-1:0] Read_Data
);

    localparam logic [XLEN-1:0] MAX_ADDR = XLEN'(MEM_BYTES - 8);

    lsu_state_e      state, state_nxt;
    logic            we_q, we_nxt;
    logic [1:0]      size_q, size_nxt;
    logic            uns_q, uns_nxt;
    logic [XLEN-1:0] wdata_q, wdata_nxt;

    logic            ready_nxt, rd_nxt, wr_nxt, rvalid_nxt, fault_nxt;
    logic [XLEN-1:0] addr_nxt, wd_nxt, rdata_nxt;

    logic [XLEN-1:0] load_c;
    logic [XLEN-1:0] store_c;

    lsu_align u_align (
        .size        (size_q),
        .is_unsigned (uns_q),
        .read_data   (Read_Data),
        .wdata       (wdata_q),
        .load_c      (load_c),
        .store_c     (store_c)
    );

    // State and all output registers; outputs are loaded from their
    // next-cycle values so each strobe lines up with its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            we_q       <= 1'b0;
            size_q     <= SZ_B;
            uns_q      <= 1'b0;
            wdata_q    <= '0;
            req_ready  <= 1'b1;
            MemRead    <= 1'b0;
            MemWrite   <= 1'b0;
            Mem_Addr   <= '0;
            Write_Data <= '0;
            resp_valid <= 1'b0;
            resp_fault <= 1'b0;
            resp_rdata <= '0;
        end else begin
            state      <= state_nxt;
            we_q       <= we_nxt;
            size_q     <= size_nxt;
            uns_q      <= uns_nxt;
            wdata_q    <= wdata_nxt;
            req_ready  <= ready_nxt;
            MemRead    <= rd_nxt;
            MemWrite   <= wr_nxt;
            Mem_Addr   <= addr_nxt;
            Write_Data <= wd_nxt;
            resp_valid <= rvalid_nxt;
            resp_fault <= fault_nxt;
            resp_rdata <= rdata_nxt;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_nxt  = state;
        we_nxt     = we_q;
        size_nxt   = size_q;
        uns_nxt    = uns_q;
        wdata_nxt  = wdata_q;
        ready_nxt  = 1'b0;
        rd_nxt     = 1'b0;
        wr_nxt     = 1'b0;
        addr_nxt   = Mem_Addr;
        wd_nxt     = Write_Data;
        rvalid_nxt = 1'b0;
        fault_nxt  = 1'b0;
        rdata_nxt  = resp_rdata;

        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    we_nxt    = req_we;
                    size_nxt  = req_size;
                    uns_nxt   = req_unsigned;
                    wdata_nxt = req_wdata;
                    if (req_addr > MAX_ADDR) begin
                        state_nxt  = S_RESP;
                        rvalid_nxt = 1'b1;
                        fault_nxt  = 1'b1;
                    end else begin
                        addr_nxt = req_addr;
                        // A full doubleword store needs no merge read.
                        if (req_we && req_size == SZ_D) begin
                            state_nxt = S_WR;
                            wr_nxt    = 1'b1;
                            wd_nxt    = req_wdata;
                        end else begin
                            state_nxt = S_RD;
                            rd_nxt    = 1'b1;
                        end
                    end
                end else begin
                    ready_nxt = 1'b1;
                end
            end
            S_RD: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (we_q) begin
                    state_nxt = S_WR;
                    wr_nxt    = 1'b1;
                    wd_nxt    = store_c;
                end else begin
                    state_nxt  = S_RESP;
                    rvalid_nxt = 1'b1;
                    rdata_nxt  = load_c;
                end
            end
            S_WR: begin
                state_nxt  = S_RESP;
                rvalid_nxt = 1'b1;
            end
            S_RESP: begin
                state_nxt = S_IDLE;
                ready_nxt = 1'b1;
            end
            default: begin
                state_nxt = S_IDLE;
                ready_nxt = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a byte-array memory and a
// byte-level reference model of memory contents and load results.
module tb_load_store_unit;

    localparam int unsigned MEM_BYTES = 64;
    localparam logic [63:0] MAX_A = 64'(MEM_BYTES - 8);

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_fault;
    logic [63:0] Mem_Addr;
    logic [63:0] Write_Data;
    logic        MemWrite;
    logic        MemRead;
    logic [63:0] Read_Data;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem    [0:MEM_BYTES-1];
    logic [7:0]  refmem [0:MEM_BYTES-1];
    logic [63:0] last_rdata;

    load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_fault   (resp_fault),
        .Mem_Addr     (Mem_Addr),
        .Write_Data   (Write_Data),
        .MemWrite     (MemWrite),
        .MemRead      (MemRead),
        .Read_Data    (Read_Data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: registered read, byte-addressed 64-bit write.
    always @(posedge clk) begin
        int ma;
        ma = int'(Mem_Addr[5:0]);
        if (MemRead)
            for (int i = 0; i < 8; i++)
                if (ma + i < MEM_BYTES) Read_Data[8*i +: 8] <= mem[ma + i];
        if (MemWrite)
            for (int i = 0; i < 8; i++)
                if (ma + i < MEM_BYTES) mem[ma + i] <= Write_Data[8*i +: 8];
    end

    // Reference load: gather bytes, then extend by plain arithmetic.
    function automatic logic [63:0] ref_load(input logic [63:0] a, input logic [1:0] sz,
                                             input logic uns);
        int n;
        logic [63:0] v;
        n = 1 << sz;
        v = '0;
        for (int i = 0; i < n; i++) v = v | (64'(refmem[int'(a) + i]) << (8 * i));
        if (!uns && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
        return v;
    endfunction

    // Reference behaviour of one request: latency, strobes, results.
    task automatic model_req(input logic we, input logic [1:0] sz, input logic uns,
                             input logic [63:0] a, input logic [63:0] wd,
                             output int lat, output logic flt, output logic [63:0] rdat,
                             output int nrd, output int nwr, output logic [63:0] word);
        int n;
        n = 1 << sz;
        word = '0; nrd = 0; nwr = 0; flt = 1'b0;
        if (a > MAX_A) begin
            lat = 1; flt = 1'b1;
        end else if (!we) begin
            lat = 3; nrd = 1;
            last_rdata = ref_load(a, sz, uns);
        end else begin
            for (int i = 0; i < n; i++) refmem[int'(a) + i] = wd[8*i +: 8];
            for (int i = 0; i < 8; i++) word[8*i +: 8] = refmem[int'(a) + i];
            nwr = 1;
            nrd = (n == 8) ? 0 : 1;
            lat = (n == 8) ? 2 : 4;
        end
        rdat = last_rdata;
    endtask

    // Drive one request (called just after a rising edge) and observe it.
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [63:0] a, input logic [63:0] wd,
                         output int lat, output int nrd, output int nwr, output logic flt,
                         output logic [63:0] rdat, output logic [63:0] wword,
                         output logic bad_bus);
        lat = -1; nrd = 0; nwr = 0; flt = 1'b0; rdat = '0; wword = '0; bad_bus = 1'b0;
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (MemRead && MemWrite) bad_bus = 1'b1;
            if ((MemRead || MemWrite) && Mem_Addr !== a) bad_bus = 1'b1;
            if (MemRead) nrd++;
            if (MemWrite) begin nwr++; wword = Write_Data; end
            if (resp_valid && lat < 0) begin lat = c; flt = resp_fault; rdat = resp_rdata; end
            @(posedge clk); #1;
            if (lat >= 0) break;
        end
    endtask

    task automatic test_reset();
        int lat, nrd, nwr; logic flt, bad; logic [63:0] rd, ww;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || MemRead !== 1'b0 ||
            MemWrite !== 1'b0 || resp_rdata !== 64'd0 || resp_fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ready=%b rv=%b rd=%b wr=%b rdata=%h flt=%b exp 1 0 0 0 0 0",
                     req_ready, resp_valid, MemRead, MemWrite, resp_rdata, resp_fault);
        end
        @(posedge clk); #1;
        issue(1'b0, 2'b11, 1'b0, 64'd0, 64'd0, lat, nrd, nwr, flt, rd, ww, bad);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || MemRead !== 1'b0 ||
            MemWrite !== 1'b0 || resp_rdata !== 64'd0) begin
            errors++;
            $display("FAIL reset_pulse: ready=%b rv=%b rd=%b wr=%b rdata=%h exp 1 0 0 0 0",
                     req_ready, resp_valid, MemRead, MemWrite, resp_rdata);
        end
        #1 rst_n = 1'b1;
        last_rdata = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_loads();
        int lat, nrd, nwr, elat, enrd, enwr; logic flt, bad, eflt;
        logic [63:0] rd, ww, erd, eww;
        model_req(1'b0, 2'b11, 1'b0, 64'd8, 64'd0, elat, eflt, erd, enrd, enwr, eww);
        issue(1'b0, 2'b11, 1'b0, 64'd8, 64'd0, lat, nrd, nwr, flt, rd, ww, bad);
        checks++;
        if (lat != 3 || rd !== 64'h0F0E0D0C0B0A0908 || flt !== 1'b0 || nrd != 1 || nwr != 0) begin
            errors++;
            $display("FAIL ld8: lat=%0d rdata=%h flt=%b rd=%0d wr=%0d exp 3 0f0e0d0c0b0a0908 0 1 0",
                     lat, rd, flt, nrd, nwr);
        end
        model_req(1'b0, 2'b01, 1'b0, 64'd5, 64'd0, elat, eflt, erd, enrd, enwr, eww);
        issue(1'b0, 2'b01, 1'b0, 64'd5, 64'd0, lat, nrd, nwr, flt, rd, ww, bad);
        checks++;
        if (lat != 3 || rd !== 64'h0605) begin
            errors++;
            $display("FAIL lh5: lat=%0d rdata=%h exp 3 0605", lat, rd);
        end
    endtask

    task automatic test_byte_store();
        int lat, nrd, nwr, elat, enrd, enwr; logic flt, bad, eflt;
        logic [63:0] rd, ww, erd, eww;
        model_req(1'b1, 2'b00, 1'b0, 64'd16, 64'hAB, elat, eflt, erd, enrd, enwr, eww);
        issue(1'b1, 2'b00, 1'b0, 64'd16, 64'hAB, lat, nrd, nwr, flt, rd, ww, bad);
        checks++;
        if (lat != 4 || nrd != 1 || nwr != 1 || ww !== 64'h17161514131211AB || bad) begin
            errors++;
            $display("FAIL sb16: lat=%0d rd=%0d wr=%0d wdata=%h bad=%b exp 4 1 1 17161514131211ab 0",
                     lat, nrd, nwr, ww, bad);
        end
        model_req(1'b0, 2'b00, 1'b0, 64'd16, 64'd0, elat, eflt, erd, enrd, enwr, eww);
        issue(1'b0, 2'b00, 1'b0, 64'd16, 64'd0, lat, nrd, nwr, flt, rd, ww, bad);
        checks++;
        if (rd !== 64'hFFFFFFFFFFFFFFAB) begin
            errors++;
            $display("FAIL lb16: rdata=%h exp ffffffffffffffab", rd);
        end
        model_req(1'b0, 2'b00, 1'b1, 64'd16, 64'd0, elat, eflt, erd, enrd, enwr, eww);
        issue(1'b0, 2'b00, 1'b1, 64'd16, 64'd0, lat, nrd, nwr, flt, rd, ww, bad);
        checks++;
        if (rd !== 64'hAB) begin
            errors++;
            $display("FAIL lbu16: rdata=%h exp ab", rd);
        end
    endtask

    task automatic test_bounds();
        int lat, nrd, nwr, elat, enrd, enwr; logic flt, bad, eflt;
        logic [63:0] rd, ww, erd, eww;
        model_req(1'b1, 2'b11, 1'b0, 64'd56, 64'h1122334455667788, elat, eflt, erd, enrd, enwr, eww);
        issue(1'b1, 2'b11, 1'b0, 64'd56, 64'h1122334455667788, lat, nrd, nwr, flt, rd, ww, bad);
        checks++;
        if (lat != 2 || nrd != 0 || nwr != 1 || ww !== 64'h1122334455667788 || flt !== 1'b0) begin
            errors++;
            $display("FAIL sd56: lat=%0d rd=%0d wr=%0d wdata=%h flt=%b exp 2 0 1 1122334455667788 0",
                     lat, nrd, nwr, ww, flt);
        end
        model_req(1'b0, 2'b11, 1'b0, 64'd56, 64'd0, elat, eflt, erd, enrd, enwr, eww);
        issue(1'b0, 2'b11, 1'b0, 64'd56, 64'd0, lat, nrd, nwr, flt, rd, ww, bad);
        checks++;
        if (rd !== 64'h1122334455667788) begin
            errors++;
            $display("FAIL ld56: rdata=%h exp 1122334455667788", rd);
        end
        model_req(1'b0, 2'b00, 1'b0, 64'd57, 64'd0, elat, eflt, erd, enrd, enwr, eww);
        issue(1'b0, 2'b00, 1'b0, 64'd57, 64'd0, lat, nrd, nwr, flt, rd, ww, bad);
        checks++;
        if (lat != 1 || flt !== 1'b1 || nrd != 0 || nwr != 0 || rd !== 64'h1122334455667788) begin
            errors++;
            $display("FAIL lb57_fault: lat=%0d flt=%b rd=%0d wr=%0d rdata=%h exp 1 1 0 0 1122334455667788",
                     lat, flt, nrd, nwr, rd);
        end
    endtask

    task automatic test_back_to_back();
        int elat, enrd, enwr; logic eflt; logic [63:0] erd_a, erd_b, eww;
        logic [3:0] ready_seen;
        int r1, r2;
        logic [63:0] d1, d2;
        model_req(1'b0, 2'b10, 1'b0, 64'd4, 64'd0, elat, eflt, erd_a, enrd, enwr, eww);
        model_req(1'b0, 2'b01, 1'b1, 64'd30, 64'd0, elat, eflt, erd_b, enrd, enwr, eww);
        r1 = -1; r2 = -1; d1 = '0; d2 = '0; ready_seen = '0;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 64'd4; req_wdata = '0;
        @(posedge clk); #1;
        req_size = 2'b01; req_unsigned = 1'b1; req_addr = 64'd30;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c <= 4) ready_seen[c-1] = req_ready;
            if (resp_valid) begin
                if (r1 < 0) begin r1 = c; d1 = resp_rdata; end
                else if (r2 < 0) begin r2 = c; d2 = resp_rdata; end
            end
            @(posedge clk); #1;
            if (c == 4) req_valid = 1'b0;
            if (r2 >= 0) break;
        end
        req_valid = 1'b0;
        checks++;
        if (ready_seen !== 4'b1000) begin
            errors++;
            $display("FAIL b2b_ready: cycles4..1=%b exp 1000", ready_seen);
        end
        checks++;
        if (r1 != 3 || d1 !== erd_a) begin
            errors++;
            $display("FAIL b2b_first: cycle=%0d rdata=%h exp 3 %h", r1, d1, erd_a);
        end
        checks++;
        if (r2 != 7 || d2 !== erd_b) begin
            errors++;
            $display("FAIL b2b_second: cycle=%0d rdata=%h exp 7 %h", r2, d2, erd_b);
        end
    endtask

    task automatic test_reset_during_wr();
        int lat, nrd, nwr; logic flt, bad; logic [63:0] rd, ww;
        logic wr_before, seen_resp;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 64'd24; req_wdata = 64'hDEADBEEF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        wr_before = MemWrite;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (wr_before !== 1'b1 || MemWrite !== 1'b0 || MemRead !== 1'b0) begin
            errors++;
            $display("FAIL rst_wr_drop: wr_before=%b wr_after=%b rd=%b exp 1 0 0",
                     wr_before, MemWrite, MemRead);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        last_rdata = '0;
        seen_resp = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (resp_valid) seen_resp = 1'b1;
        end
        checks++;
        if (seen_resp !== 1'b0) begin
            errors++;
            $display("FAIL rst_wr_noresp: resp seen=%b exp 0", seen_resp);
        end
        @(posedge clk); #1;
        issue(1'b0, 2'b11, 1'b0, 64'd24, 64'd0, lat, nrd, nwr, flt, rd, ww, bad);
        last_rdata = rd;
        checks++;
        if (lat != 3 || rd !== 64'h1F1E1D1C1B1A1918 || rd !== ref_load(64'd24, 2'b11, 1'b0)) begin
            errors++;
            $display("FAIL rst_wr_mem: lat=%0d rdata=%h exp 3 1f1e1d1c1b1a1918", lat, rd);
        end
    endtask

    task automatic test_random();
        int lat, nrd, nwr, elat, enrd, enwr, r; logic flt, bad, eflt;
        logic [63:0] rd, ww, erd, eww, a, wd;
        logic we, uns; logic [1:0] sz;
        for (int k = 0; k < 60; k++) begin
            we  = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 3));
            uns = 1'($urandom_range(0, 1));
            wd  = {$urandom, $urandom};
            r   = int'($urandom_range(0, 9));
            if (r == 0)      a = {$urandom, $urandom} | 64'h100;
            else if (r == 1) a = 64'($urandom_range(57, 80));
            else             a = 64'($urandom_range(0, 56));
            model_req(we, sz, uns, a, wd, elat, eflt, erd, enrd, enwr, eww);
            issue(we, sz, uns, a, wd, lat, nrd, nwr, flt, rd, ww, bad);
            checks++;
            if (lat != elat || flt !== eflt || rd !== erd || nrd != enrd || nwr != enwr || bad) begin
                errors++;
                $display("FAIL rand%0d we=%b sz=%0d a=%h: lat=%0d flt=%b rdata=%h rd=%0d wr=%0d bad=%b exp %0d %b %h %0d %0d 0",
                         k, we, sz, a, lat, flt, rd, nrd, nwr, bad, elat, eflt, erd, enrd, enwr);
            end
            if (we && !eflt) begin
                checks++;
                if (ww !== eww) begin
                    errors++;
                    $display("FAIL rand%0d_wdata: got %h exp %h", k, ww, eww);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) begin
            mem[i]    = 8'(i);
            refmem[i] = 8'(i);
        end
        last_rdata   = '0;
        Read_Data    = '0;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        test_reset();
        test_loads();
        test_byte_store();
        test_bounds();
        test_back_to_back();
        test_reset_during_wr();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator-side master for the processor's data memory port. Accepts one load or store request at a time from the execute stage and converts it into the data memory's `Mem_Addr`/`MemRead`/`MemWrite` cycles. Handles the memory's one-cycle registered read latency, sign/zero extension for sub-doubleword loads, read-modify-write for sub-doubleword stores, and out-of-range address faults. Sits between the datapath and the byte-addressed 64-bit data memory.

## Interface

Parameters:

- `MEM_BYTES`, 64: size of the attached data memory in bytes. The highest legal access address is `MEM_BYTES-8`.

Ports. One clock; reset is asynchronous and active-low.

- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit idle and able to accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  access size: 00 byte, 01 half, 10 word, 11 double.
- `req_unsigned`  in  1  zero-extend a load; ignored for stores and for double loads.
- `req_addr`  in  64  byte address.
- `req_wdata`  in  64  store data; low bytes are used for sizes below double.
- `resp_valid`  out  1  single-cycle response pulse.
- `resp_rdata`  out  64  extended load data; holds its value until the next load response.
- `resp_fault`  out  1  qualifies `resp_valid`; set when the address is out of range.
- `Mem_Addr`  out  64  memory byte address.
- `Write_Data`  out  64  memory write data.
- `MemWrite`  out  1  memory write strobe.
- `MemRead`  out  1  memory read strobe.
- `Read_Data`  in  64  memory read data. It is valid the cycle after `MemRead` is sampled.

## Operation

- **Reset values.** All outputs are 0 except `req_ready`, which is 1. The FSM goes to IDLE and all internal registers clear.
- **FSM states:** IDLE, RD, WAIT, WR, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, latch `we`, `size`, `unsigned`, `addr` and `wdata`.
  - If `addr > MEM_BYTES-8` (full 64-bit unsigned compare, any size), go to RESP with fault set.
  - Else a double store goes to WR; all other requests go to RD.
- **RD.** `MemRead`=1 and `Mem_Addr`=addr. Next state is WAIT.
- **WAIT.** `Read_Data` is valid in this cycle.
  - Load: register the extracted and extended value into `resp_rdata`, then go to RESP.
  - Byte/half/word extraction uses `Read_Data[7:0]`, `[15:0]` or `[31:0]`. The upper bits are the sign bit replicated, or 0 when `unsigned` is set.
  - Double load: the value is taken unmodified.
  - Store: the merge buffer becomes `{Read_Data[63:8], wdata[7:0]}`, `{Read_Data[63:16], wdata[15:0]}` or `{Read_Data[63:32], wdata[31:0]}` according to size. Next state is WR.
- **WR.** `MemWrite`=1, `Mem_Addr`=addr, and `Write_Data` = merge buffer (or `wdata` for a double store). Next state is RESP.
- **RESP.** `resp_valid`=1 for exactly one cycle, with `resp_fault` valid. Next state is IDLE.
- **Faults.** A faulted request never asserts `MemRead` or `MemWrite`, and `resp_rdata` is unchanged.
- **Mutual exclusion.** `MemRead` and `MemWrite` are never high in the same cycle.
- **Address holding.** `Mem_Addr` holds the last latched address between accesses.
- **Handshake.** A request is accepted only in IDLE. There is no response backpressure.

## Timing

Cycle 0 is the cycle in which `req_valid` and `req_ready` are sampled. `resp_valid` rises in:

- Load: cycle 3 (RD=1, WAIT=2).
- Double store: cycle 2 (WR=1).
- Sub-doubleword store: cycle 4 (RD=1, WAIT=2, WR=3).
- Fault: cycle 1.
- Next acceptance is possible in the cycle after RESP.

Reset mid-operation:

- Asserting `rst_n` low drops `MemRead`/`MemWrite` immediately.
- A WR interrupted before its clock edge leaves memory unchanged.
- No response is produced for the aborted request.

## Structure

- **Package `lsu_pkg`:** size encodings (`SZ_B`, `SZ_H`, `SZ_W`, `SZ_D`) and the FSM state enum.
- **Sub-module `lsu_align`:** combinational; takes size, unsigned, `Read_Data` and `wdata` and produces the extended load value and the merged store word.
- **Top level:** the FSM and registers.

## Test plan

Memory is preloaded with byte `i` = `i`.

- **Reset.** Pulse `rst_n` low mid-idle. Expect `req_ready`=1, `resp_valid`=`MemRead`=`MemWrite`=0 and `resp_rdata`=0.
- **Plain loads.**
  - `ld` at 8: response in cycle 3 with rdata `0x0F0E0D0C0B0A0908`.
  - `lh` at 5: rdata `0x0605`.
- **Byte store then loads.**
  - `sb` 0xAB at 16: one `MemRead` pulse, then one `MemWrite` with `Write_Data` `0x17161514131211AB`, response in cycle 4.
  - `lb` at 16: `0xFFFFFFFFFFFFFFAB`.
  - `lbu` at 16: `0xAB`.
- **Bounds.**
  - `sd` 0x1122334455667788 at 56 completes in cycle 2; a subsequent `ld` at 56 returns the same value.
  - `lb` at 57: `resp_fault`=1 in cycle 1, no memory strobe, `resp_rdata` unchanged.
- **Back-to-back.** Hold `req_valid` high with two loads. Expect `req_ready` low during RD/WAIT/RESP, and the second request accepted the cycle after the first `resp_valid`.
- **Reset during WR.** Drop `rst_n` during the WR cycle of `sw` 0xDEADBEEF at 24, before the edge. Expect `MemWrite` to fall immediately, no response, and a later `ld` at 24 returning `0x1F1E1D1C1B1A1918`.
